// File: rtl/adc_frame_align_ctrl.sv
// -----------------------------------------------------------------------------
// adc_frame_align_ctrl
//
// Purpose:
//   Sequences frame-word alignment of a deserialized LVDS ADC stream before
//   the channel-swap / sign-extend stage. The block watches the deserialized
//   frame-clock word and issues single-cycle BitSlip pulses to the
//   deserializers until the expected frame pattern is seen MatchCount times
//   in a row. It then asserts Aligned, which gates downstream sample capture.
//   While locked it keeps watching the frame word and declares loss of lock
//   after LossCount consecutive mismatches.
//
// Optional feature (compile-time macro ADC_ALIGN_AUTO_RELOCK_EN):
//   defined   : loss of lock goes straight back to SETTLE with all counters
//               cleared, so realignment starts without an AlignStart.
//   undefined : loss of lock returns to IDLE and waits for AlignStart.
//   LockLost pulses in both builds.
//
// Parameters:
//   AdcBits      ADC resolution; only FrmWord[AdcBits-1:0] is compared.
//   FrmPattern   expected frame word (low AdcBits bits used).
//   SettleCycles cycles waited after a start or a slip before comparing (>=1).
//   MatchCount   consecutive matches required to lock (>=1).
//   MaxSlips     slip attempts allowed before declaring failure (<=31).
//   LossCount    consecutive mismatches in LOCKED that declare loss (>=1).
//
// Ports:
//   FrmClk      in   frame clock, all logic on the rising edge
//   Rst         in   asynchronous active-high reset
//   AlignStart  in   single-cycle request to (re)start alignment
//   FrmWord     in   16-bit deserialized frame-clock word, valid every cycle
//   BitSlip     out  single-cycle slip pulse to all deserializers
//   Aligned     out  high while LOCKED
//   AlignFail   out  high while FAIL
//   LockLost    out  single-cycle pulse on loss of lock
//   SlipCnt     out  slips issued in the current attempt (saturating)
//   StateDbg    out  current FSM state encoding, for debug/observation
//
// Handshake: AlignStart is a level sampled on every rising edge; there is no
// ready/acknowledge. A high sample is a request. It is honoured on the same
// edge in every state except SLIP, where the slip pulse finishes first and the
// restart happens on the following edge.
//
// All outputs are registered: each output flop is loaded from the next-state
// decode so that it lines up with the state register.
// -----------------------------------------------------------------------------
module adc_frame_align_ctrl #(
    parameter int          AdcBits      = 14,
    parameter logic [15:0] FrmPattern   = 16'h3F80,
    parameter int          SettleCycles = 8,
    parameter int          MatchCount   = 4,
    parameter int          MaxSlips     = 14,
    parameter int          LossCount    = 3
) (
    input  logic        FrmClk,
    input  logic        Rst,
    input  logic        AlignStart,
    input  logic [15:0] FrmWord,
    output logic        BitSlip,
    output logic        Aligned,
    output logic        AlignFail,
    output logic        LockLost,
    output logic [4:0]  SlipCnt,
    output logic [2:0]  StateDbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    // Only the low AdcBits bits of the frame word take part in the compare.
    // The mask is applied to the XOR so the unused upper bits never matter.
    localparam logic [15:0] FRM_MASK    = 16'((32'd1 << AdcBits) - 32'd1);

    // Terminal counts. The counters run from 0, so "reached N" is "== N-1"
    // at the edge where the N-th event is seen.
    localparam logic [7:0]  SETTLE_LAST = 8'(SettleCycles - 1);
    localparam logic [7:0]  MATCH_LAST  = 8'(MatchCount - 1);
    localparam logic [7:0]  LOSS_LAST   = 8'(LossCount - 1);
    localparam logic [4:0]  MAX_SLIPS   = 5'(MaxSlips);

    // State and counters.
    state_t      state_q,      state_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [7:0]  match_cnt_q,  match_cnt_d;
    logic [7:0]  loss_cnt_q,   loss_cnt_d;
    logic [4:0]  slip_cnt_q,   slip_cnt_d;

    // Registered outputs.
    logic        bit_slip_q,   bit_slip_d;
    logic        aligned_q,    aligned_d;
    logic        align_fail_q, align_fail_d;
    logic        lock_lost_q,  lock_lost_d;

    logic        frm_match;

    always_comb begin
        frm_match = (((FrmWord ^ FrmPattern) & FRM_MASK) == 16'd0);
    end

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        match_cnt_d  = match_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        lock_lost_d  = 1'b0;

        if (AlignStart && (state_q != ST_SLIP)) begin
            // Restart from anywhere except SLIP: the slip pulse is never cut
            // short by a restart request (only reset can truncate it).
            state_d      = ST_SETTLE;
            settle_cnt_d = 8'd0;
            match_cnt_d  = 8'd0;
            loss_cnt_d   = 8'd0;
            slip_cnt_d   = 5'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end

                ST_SETTLE: begin
                    // Frame words are ignored while the deserializers settle.
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d     = ST_CHECK;
                        match_cnt_d = 8'd0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 8'd1;
                    end
                end

                ST_CHECK: begin
                    if (frm_match) begin
                        if (match_cnt_q == MATCH_LAST) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = 8'd0;
                            loss_cnt_d  = 8'd0;
                        end else begin
                            match_cnt_d = match_cnt_q + 8'd1;
                        end
                    end else begin
                        // Any mismatch restarts the match run. The slip budget
                        // is checked here, before another slip is spent.
                        match_cnt_d = 8'd0;
                        if (slip_cnt_q == MAX_SLIPS) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_SLIP;
                        end
                    end
                end

                ST_SLIP: begin
                    // Exactly one cycle here, so BitSlip can never be high on
                    // two consecutive cycles.
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 8'd0;
                    match_cnt_d  = 8'd0;
                    if (AlignStart) begin
                        // Restart requested during the pulse: begin a fresh
                        // attempt instead of counting this slip.
                        loss_cnt_d = 8'd0;
                        slip_cnt_d = 5'd0;
                    end else if (slip_cnt_q < MAX_SLIPS) begin
                        slip_cnt_d = slip_cnt_q + 5'd1;
                    end
                end

                ST_LOCKED: begin
                    if (frm_match) begin
                        loss_cnt_d = 8'd0;
                    end else if (loss_cnt_q == LOSS_LAST) begin
                        lock_lost_d = 1'b1;
                        loss_cnt_d  = 8'd0;
`ifdef ADC_ALIGN_AUTO_RELOCK_EN
                        state_d      = ST_SETTLE;
                        settle_cnt_d = 8'd0;
                        match_cnt_d  = 8'd0;
                        slip_cnt_d   = 5'd0;
`else
                        // SlipCnt keeps the value of the last attempt for
                        // debug until the next AlignStart.
                        state_d = ST_IDLE;
`endif
                    end else begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end

                ST_FAIL: begin
                    // Held until AlignStart (handled above) or reset.
                    state_d = ST_FAIL;
                end

                default: begin
                    state_d      = ST_IDLE;
                    settle_cnt_d = 8'd0;
                    match_cnt_d  = 8'd0;
                    loss_cnt_d   = 8'd0;
                    slip_cnt_d   = 5'd0;
                end
            endcase
        end
    end

    // Output decode from the next state so the output flops change on the
    // same edge as the state register.
    always_comb begin
        bit_slip_d   = (state_d == ST_SLIP);
        aligned_d    = (state_d == ST_LOCKED);
        align_fail_d = (state_d == ST_FAIL);
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge FrmClk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Counters and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge FrmClk or posedge Rst) begin
        if (Rst) begin
            settle_cnt_q <= 8'd0;
            match_cnt_q  <= 8'd0;
            loss_cnt_q   <= 8'd0;
            slip_cnt_q   <= 5'd0;
            bit_slip_q   <= 1'b0;
            aligned_q    <= 1'b0;
            align_fail_q <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            bit_slip_q   <= bit_slip_d;
            aligned_q    <= aligned_d;
            align_fail_q <= align_fail_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    always_comb begin
        BitSlip   = bit_slip_q;
        Aligned   = aligned_q;
        AlignFail = align_fail_q;
        LockLost  = lock_lost_q;
        SlipCnt   = slip_cnt_q;
        StateDbg  = state_q;
    end

endmodule

// File: doc/adc_frame_align_ctrl.md
Name: adc_frame_align_ctrl

Overview:
Sequences frame-word alignment of the deserialized LVDS ADC stream ahead of the channel-swap/sign-extend stage. It watches the deserialized frame-clock word and issues single-cycle BitSlip pulses to the deserializers until the expected frame pattern is received repeatedly. It then asserts Aligned, which gates downstream sample capture. In LOCKED it keeps monitoring the frame word for loss of lock.

Parameters:
AdcBits, 14, ADC resolution (8/10/12/14/16); only FrmWord[AdcBits-1:0] is compared.
FrmPattern, 16'h3F80, expected frame word; low AdcBits bits used.
SettleCycles, 8, cycles waited after start or after each slip before comparing (>=1).
MatchCount, 4, consecutive matches required to lock (>=1).
MaxSlips, 14, slip attempts allowed before failure (normally = AdcBits).
LossCount, 3, consecutive mismatches in LOCKED that declare loss of lock (>=1).

Ports:
FrmClk  input  1  frame clock; all logic on rising edge.
Rst  input  1  asynchronous, active-high reset.
AlignStart  input  1  single-cycle request to (re)start alignment.
FrmWord  input  16  deserialized frame-clock word, valid every FrmClk.
BitSlip  output  1  single-cycle slip pulse to all deserializers.
Aligned  output  1  high while in LOCKED.
AlignFail  output  1  high while in FAIL.
LockLost  output  1  single-cycle pulse on LOCKED->loss transition.
SlipCnt  output  5  slips issued in current attempt.

Behaviour:
- Clock FrmClk; reset Rst is asynchronous and active-high. Under Rst all outputs and counters are 0, state = IDLE.
- All outputs are registered. Match = (FrmWord[AdcBits-1:0] == FrmPattern[AdcBits-1:0]).
- States: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- IDLE: wait. AlignStart -> SETTLE, with SlipCnt and MatchCnt cleared.
- SETTLE: stay exactly SettleCycles cycles, then -> CHECK. Frame words are ignored.
- CHECK: on each Match, MatchCnt++. When MatchCnt reaches MatchCount -> LOCKED.
- CHECK, first mismatch: MatchCnt cleared. If SlipCnt == MaxSlips -> FAIL, else -> SLIP.
- SLIP: one cycle. BitSlip=1 for exactly this cycle, SlipCnt++, then -> SETTLE.
- BitSlip is never high two consecutive cycles.
- LOCKED: Aligned=1. Each mismatch increments LossCnt; a Match clears it.
- LOCKED, LossCnt reaching LossCount: LockLost pulses 1 cycle, Aligned drops the same cycle, state -> IDLE.
- FAIL: AlignFail=1, held until AlignStart or Rst.
- AlignStart in any state other than SLIP restarts: -> SETTLE, counters cleared, Aligned/AlignFail drop next cycle.
- AlignStart during SLIP: the pulse completes, then -> SETTLE with counters cleared.
- SlipCnt saturates at MaxSlips. SlipCnt holds its value in LOCKED/FAIL for debug.
- Rst mid-operation: immediate return to IDLE; an in-flight BitSlip is truncated.

Optional Feature:
ADC_ALIGN_AUTO_RELOCK_EN
- Defined: on loss of lock, go directly to SETTLE (counters cleared) instead of IDLE, with no AlignStart needed. LockLost still pulses.
- Undefined: loss of lock goes to IDLE and waits for AlignStart.

Test Plan:
1. Reset released, FrmWord=16'h3F80, AlignStart pulse -> no BitSlip; Aligned=1 at cycle 1+8+4 after AlignStart; SlipCnt=0.
2. FrmWord rotated by 3 bits within 14 bits, rotating back one bit per BitSlip -> exactly 3 BitSlip pulses, each separated by >=9 cycles; Aligned=1; SlipCnt=3.
3. FrmWord fixed at 16'h0000 -> 14 BitSlip pulses, then AlignFail=1 with SlipCnt=14, Aligned=0; later AlignStart clears AlignFail.
4. LOCKED, then 2 mismatches, 1 match, 2 mismatches -> stays locked. Then 3 consecutive mismatches -> LockLost 1-cycle pulse, Aligned=0, state IDLE (SETTLE with ADC_ALIGN_AUTO_RELOCK_EN).
5. CHECK with 3 matches then 1 mismatch (MatchCount=4) -> BitSlip issued, no lock; Rst asserted during SLIP -> BitSlip=0 immediately, all outputs 0.
6. AdcBits=12, FrmPattern=16'hFFC0 with FrmWord[15:12] random -> upper bits ignored, lock achieved with no slips.
